// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Holds renamed micro-ops for one functional-unit class, wakes busy operands
// by snooping four CDBs and issues the oldest fully-ready entry.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   Defined   : an entry whose last busy operand(s) match a CDB this cycle is
//               issuable in the same cycle, carrying the CDB value.
//   Undefined : wakeup-to-issue takes one cycle (capture, then issue).
//
// Packed layouts (MSB .. LSB):
//   rs_t  : {busy_1, busy_2, rs1_rob[TAG_W], rs2_rob[TAG_W], r1_v[XLEN],
//            r2_v[XLEN], rob_entry[TAG_W], ops[OPS_W], imm[XLEN], pc[XLEN]}
//   cdb_t : {valid, tag[TAG_W], value[XLEN]}
//   rvfi_data : opaque RVFI_W-bit record carried alongside the op
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          drop all entries (mispredict)
//   dispatch       write rs_in/rvfi_in into the lowest free entry
//   rs_in, rvfi_in op and rvfi record from rename
//   cdb1..cdb4     result broadcasts; cdb1 has the highest priority
//   fu_ready       functional unit accepts the presented op
//   rs_full        no free entry (registered state only)
//   issue_valid    issue_rs/issue_rvfi hold the oldest ready op
//   issue_rs       op to the functional unit, busy bits clear
//   issue_rvfi     matching rvfi record
//   count          occupied entries
//
// Handshake: an op transfers at a rising edge where issue_valid && fu_ready
// (and no flush). issue_valid never waits on fu_ready. While fu_ready is low
// the presented op may still change if a strictly older entry becomes ready.
// ---------------------------------------------------------------------------
module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int XLEN   = 32,
  parameter int OPS_W  = 8,
  parameter int RVFI_W = 64,
  localparam int RS_W  = 2 + 3*TAG_W + OPS_W + 4*XLEN,
  localparam int CDB_W = 1 + TAG_W + XLEN,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch,
  input  logic [RS_W-1:0]   rs_in,
  input  logic [RVFI_W-1:0] rvfi_in,
  input  logic [CDB_W-1:0]  cdb1,
  input  logic [CDB_W-1:0]  cdb2,
  input  logic [CDB_W-1:0]  cdb3,
  input  logic [CDB_W-1:0]  cdb4,
  input  logic              fu_ready,
  output logic              rs_full,
  output logic              issue_valid,
  output logic [RS_W-1:0]   issue_rs,
  output logic [RVFI_W-1:0] issue_rvfi,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W  = $clog2(DEPTH);
  // Field offsets inside the packed rs_t.
  localparam int R2V_LO = 2*XLEN + OPS_W + TAG_W;
  localparam int R1V_LO = R2V_LO + XLEN;
  localparam int RS2_LO = R1V_LO + XLEN;
  localparam int RS1_LO = RS2_LO + TAG_W;
  localparam int B2_BIT = RS1_LO + TAG_W;
  localparam int B1_BIT = B2_BIT + 1;

  // Entry state. r_older[i][j] = 1 means entry j is older than entry i.
  logic [DEPTH-1:0]  r_valid;
  logic [RS_W-1:0]   r_rs    [DEPTH];
  logic [RVFI_W-1:0] r_rvfi  [DEPTH];
  logic [DEPTH-1:0]  r_older [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // CDB fields; index 0 is cdb1.
  logic [3:0]        w_cdb_v;
  logic [TAG_W-1:0]  w_cdb_tag [4];
  logic [XLEN-1:0]   w_cdb_val [4];

  logic [DEPTH-1:0]  w_hit1, w_hit2, w_wake1, w_wake2;
  logic [XLEN-1:0]   w_val1 [DEPTH];
  logic [XLEN-1:0]   w_val2 [DEPTH];
  logic [RS_W-1:0]   w_eff  [DEPTH];
  logic [DEPTH-1:0]  w_ready, w_sel;
  logic [DEPTH-1:0]  w_alloc_oh;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic              w_do_disp, w_do_issue;

  always_comb begin
    w_cdb_v      = {cdb4[CDB_W-1], cdb3[CDB_W-1], cdb2[CDB_W-1], cdb1[CDB_W-1]};
    w_cdb_tag[0] = cdb1[XLEN +: TAG_W];
    w_cdb_tag[1] = cdb2[XLEN +: TAG_W];
    w_cdb_tag[2] = cdb3[XLEN +: TAG_W];
    w_cdb_tag[3] = cdb4[XLEN +: TAG_W];
    w_cdb_val[0] = cdb1[XLEN-1:0];
    w_cdb_val[1] = cdb2[XLEN-1:0];
    w_cdb_val[2] = cdb3[XLEN-1:0];
    w_cdb_val[3] = cdb4[XLEN-1:0];
  end

  // Tag match per entry operand. Scanning cdb4 down to cdb1 lets the
  // lowest-numbered matching bus overwrite the value last, giving it priority.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_hit1[e] = 1'b0;
      w_hit2[e] = 1'b0;
      w_val1[e] = '0;
      w_val2[e] = '0;
      for (int k = 3; k >= 0; k--) begin
        if (w_cdb_v[k] && (w_cdb_tag[k] == r_rs[e][RS1_LO +: TAG_W])) begin
          w_hit1[e] = 1'b1;
          w_val1[e] = w_cdb_val[k];
        end
        if (w_cdb_v[k] && (w_cdb_tag[k] == r_rs[e][RS2_LO +: TAG_W])) begin
          w_hit2[e] = 1'b1;
          w_val2[e] = w_cdb_val[k];
        end
      end
      w_wake1[e] = r_valid[e] && r_rs[e][B1_BIT] && w_hit1[e];
      w_wake2[e] = r_valid[e] && r_rs[e][B2_BIT] && w_hit2[e];
    end
  end

  // Effective payload seen by the issue logic.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_eff[e] = r_rs[e];
`ifdef RS_WAKEUP_BYPASS_EN
      if (w_wake1[e]) begin
        w_eff[e][B1_BIT]            = 1'b0;
        w_eff[e][R1V_LO +: XLEN]    = w_val1[e];
      end
      if (w_wake2[e]) begin
        w_eff[e][B2_BIT]            = 1'b0;
        w_eff[e][R2V_LO +: XLEN]    = w_val2[e];
      end
`endif
      w_ready[e] = r_valid[e] && !w_eff[e][B1_BIT] && !w_eff[e][B2_BIT];
    end
  end

  // Oldest ready: ready and no ready entry is older than it.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_sel[e] = w_ready[e] && ((r_older[e] & w_ready) == '0);
    end
  end

  always_comb begin
    issue_rs   = '0;
    issue_rvfi = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_sel[e]) begin
        issue_rs   = w_eff[e];
        issue_rvfi = r_rvfi[e];
      end
    end
  end

  assign issue_valid = |w_sel;

  // Lowest-index free entry.
  always_comb begin
    w_alloc_oh  = '0;
    w_alloc_idx = '0;
    for (int e = DEPTH-1; e >= 0; e--) begin
      if (!r_valid[e]) begin
        w_alloc_oh  = '0;
        w_alloc_oh[e] = 1'b1;
        w_alloc_idx = IDX_W'(e);
      end
    end
  end

  assign rs_full    = (r_count == CNT_W'(DEPTH));
  assign count      = r_count;
  assign w_do_disp  = dispatch && !rs_full && !flush;
  assign w_do_issue = issue_valid && fu_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_older[e] <= '0;
      end
    end else if (flush) begin
      // Age rows may go stale here; allocation rewrites them before use.
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_wake1[e]) begin
          r_rs[e][B1_BIT]         <= 1'b0;
          r_rs[e][R1V_LO +: XLEN] <= w_val1[e];
        end
        if (w_wake2[e]) begin
          r_rs[e][B2_BIT]         <= 1'b0;
          r_rs[e][R2V_LO +: XLEN] <= w_val2[e];
        end
        if (w_do_issue && w_sel[e]) begin
          r_valid[e] <= 1'b0;
        end
        if (w_do_disp && w_alloc_oh[e]) begin
          r_valid[e] <= 1'b1;
          r_rs[e]    <= rs_in;
          r_rvfi[e]  <= rvfi_in;
          r_older[e] <= r_valid;
        end
        // The new entry is older than nobody; clears stale bits from the
        // previous occupant of that slot.
        if (w_do_disp) begin
          r_older[e][w_alloc_idx] <= 1'b0;
        end
      end
      r_count <= r_count + CNT_W'(w_do_disp) - CNT_W'(w_do_issue);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dispatch && rs_full))
        else $warning("reservation_station: dispatch while full ignored");
      assert (r_count <= CNT_W'(DEPTH))
        else $error("reservation_station: count above DEPTH");
      assert (!(w_do_issue && (r_count == '0)))
        else $error("reservation_station: count underflow");
      assert (r_count == CNT_W'($countones(r_valid)))
        else $error("reservation_station: count disagrees with valid bits");
    end
  end
`endif

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Holds renamed micro-ops from the rename/dispatch stage for one functional-unit class (ALU, MUL, CMP or LD/ST); one instance per class.
- Snoops the four CDBs to wake up operands that were still busy at dispatch.
- Issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.
- Drives rs_full back to rename, which uses it combinationally to gate dispatch.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..16).
- TAG_W, 4, ROB tag width; must equal the width of rs_t.rs1_rob and rs_t.rs2_rob and cdb_t.tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (mispredict); drops all entries
- dispatch  in  1  write rs_in into a free entry this cycle
- rs_in  in  $bits(rs_t)  renamed op from rename (busy_1/busy_2, r1_v/r2_v, rs1_rob/rs2_rob, rob_entry, ops, imm, pc)
- rvfi_in  in  $bits(rvfi_data)  rvfi record travelling with the op
- cdb1..cdb4  in  $bits(cdb_t) each  broadcast buses (valid, tag, value)
- fu_ready  in  1  functional unit accepts an op this cycle
- rs_full  out  1  no free entry
- issue_valid  out  1  issue_rs/issue_rvfi hold a ready op
- issue_rs  out  $bits(rs_t)  op to functional unit, busy_1=busy_2=0
- issue_rvfi  out  $bits(rvfi_data)  matching rvfi record
- count  out  $clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Reset (clk edge with rst=1):
  - All entries invalid; age matrix cleared.
  - count=0, rs_full=0, issue_valid=0, issue_rs='0, issue_rvfi='0.
- Per-entry state: valid bit, rs_t payload, rvfi_data payload, one age-matrix row.
- Allocation:
  - On dispatch=1 with rs_full=0, rs_in is written into the lowest-index invalid entry at the clock edge.
  - The new entry is marked younger than every currently valid entry.
  - dispatch=1 with rs_full=1 is a protocol violation: the write is ignored and a simulation assertion fires.
- rs_full = (count == DEPTH). It is computed from registered state only; there is no same-cycle credit from an issue.
- Wakeup:
  - Applies to each valid entry with busy_1=1. If any cdbN.valid && cdbN.tag == rs1_rob, capture that value into r1_v and clear busy_1 at the edge.
  - busy_2/rs2_rob/r2_v are handled identically.
  - Priority among multiple matching CDBs: cdb1 > cdb2 > cdb3 > cdb4.
  - Wakeup does not apply to the entry being written this cycle; rename has already resolved same-cycle CDB matches.
- Ready = valid && !busy_1 && !busy_2.
- Issue select:
  - The oldest ready entry per the age matrix.
  - issue_valid, issue_rs and issue_rvfi are combinational from registered entry state.
  - When no entry is ready: issue_valid=0 and issue_rs/issue_rvfi='0.
- Handshake:
  - An entry is freed at the edge where issue_valid && fu_ready.
  - While fu_ready=0 the outputs stay stable unless a strictly older entry becomes ready. The functional unit must not rely on stability without accepting.
- Latency:
  - Op dispatched at edge N with busy=0 can issue in the cycle after edge N (1 cycle minimum).
  - Op woken at edge N can issue in the cycle after edge N.
- Simultaneous events:
  - Dispatch and issue at the same edge: count unchanged. The freed slot is reusable only from the next cycle.
  - Wakeup and issue in the same cycle operate on different entries; no conflict.
- Flush:
  - flush=1 at an edge invalidates all entries and sets count=0.
  - Dispatch in the same cycle is dropped.
  - issue_valid is still driven combinationally during the flush cycle. The functional unit must qualify it with flush.
- rst has priority over flush; flush has priority over dispatch and issue.
- count arithmetic:
  - count_next = count + (dispatch accepted) - (issue accepted).
  - Never exceeds DEPTH, never underflows (assertions).

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose only remaining busy operand(s) match a valid CDB this cycle counts as ready this cycle.
  - issue_rs carries the CDB value in place of the stale r1_v/r2_v, with busy cleared.
  - Cuts wakeup-to-issue latency from 1 cycle to 0.
  - If such an entry is issued, the edge frees it; normal capture is skipped.
- Undefined: wakeup-to-issue is 1 cycle as described in Behaviour; no CDB-to-issue combinational path.

Test Plan:
- Reset then four dispatches with busy_1=busy_2=0 (pc 0x60000000..0x6000000C), fu_ready=0:
  - Required: rs_full=1 after the 4th edge, count=4.
  - Then fu_ready=1: issues in pc order 0x..00, 04, 08, 0C, one per cycle; rs_full drops after the first accept.
- Dispatch an op with busy_1=1, rs1_rob=3; next cycle drive cdb2={valid=1, tag=3, value=0xDEADBEEF}:
  - Required (macro off): issue_valid=1 the following cycle with issue_rs.r1_v=0xDEADBEEF, busy_1=0.
  - Required (macro on): issue_valid=1 in the CDB cycle itself with the same value.
- Older entry (A) busy on tag 5, younger entry (B) ready:
  - Required: B issues first.
  - Then cdb4 tag 5 value 0x11: A issues next with r1_v=0x11.
  - cdb1 and cdb3 both tag 5 with values 0x22/0x33 in the same cycle: captured value = 0x22.
- Full RS, issue accepted and dispatch=1 at the same edge: dispatch is illegal because rs_full=1.
  - Required: assertion fires, count=3, payload not written.
  - Repeat with count=3: count stays 3.
- Three valid entries, then flush=1 with dispatch=1:
  - Required: count=0, rs_full=0, issue_valid=0 the next cycle, dispatched op absent.
  - rst asserted mid-stream gives the same result with all outputs at reset values.
